// File: rtl/add_sub_sweeper.sv
// add_sub_sweeper: sequential self-checking initiator for a combinational
// WIDTH-bit adder/subtractor. It walks every operand pair for the selected
// operation(s), waits SETTLE cycles per vector and checks {C,S} against an
// internal golden model. It reports the error count, the first failing vector
// and pass/fail.
module add_sub_sweeper #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic               M,
  input  logic [WIDTH-1:0]   S,
  input  logic               C,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [2*WIDTH:0]   fail_vec
);

  localparam int IW = 2*WIDTH + 1;

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, FINISH} state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               m_q, m_d;
  logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [IW-1:0]      err_q, err_d, fail_q, fail_d;

  logic [WIDTH-1:0]   vec_a, vec_b;
  logic               vec_m, last_vec, mismatch;

  // Reference result in exactly WIDTH+1 bits; subtract is A + ~B + 1, so the
  // carry-out is the "no borrow" flag.
  function automatic logic [WIDTH:0] golden(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic             m);
    logic [WIDTH:0] r;
    if (m) r = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    else   r = {1'b0, a} + {1'b0, b};
    return r;
  endfunction

  // Split the vector index into operands; mode bit 1 selects the interleaved
  // add/subtract ordering where M is the least significant index bit.
  always_comb begin
    if (mode_q[1]) begin
      vec_a    = idx_q[IW-1:WIDTH+1];
      vec_b    = idx_q[WIDTH:1];
      vec_m    = idx_q[0];
      last_vec = &idx_q;
    end else begin
      vec_a    = idx_q[2*WIDTH-1:WIDTH];
      vec_b    = idx_q[WIDTH-1:0];
      vec_m    = mode_q[0];
      last_vec = &idx_q[2*WIDTH-1:0];
    end
    mismatch = ({C, S} != golden(a_q, b_q, m_q));
  end

  // Next-state and datapath updates for the sweep FSM.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          mode_d  = mode;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      DRIVE: begin
        a_d     = vec_a;
        b_d     = vec_b;
        m_d     = vec_m;
        cnt_d   = 4'(SETTLE);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = CHECK;
      end
      CHECK: begin
        if (mismatch) begin
          if (!(&err_q)) err_d = err_q + IW'(1);
          if (err_q == '0) fail_d = {a_q, b_q, m_q};
        end
        if (last_vec) begin
          state_d = FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = !mismatch && (err_q == '0);
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = DRIVE;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any sweep immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign M         = m_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_add_sub_sweeper.sv
// Directed bench for add_sub_sweeper (WIDTH=4, SETTLE=1) with a bench-side
// adder/subtractor that can have faults switched in.
module tb_add_sub_sweeper;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [1:0]     mode = 2'b00;
  logic [W-1:0]   A, B, S;
  logic           M, C, busy, done, pass;
  logic [2*W:0]   err_count, fail_vec;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc = 0;
  int d0 = 0;

  logic fault_s0 = 1'b0;
  logic fault_csub = 1'b0;
  logic fault_dir = 1'b0;
  logic [W:0] res;

  add_sub_sweeper #(.WIDTH(W), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .A(A), .B(B), .M(M), .S(S), .C(C),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  always #5 clk = ~clk;

  // Attached adder/subtractor: two vectors return hand-computed constants,
  // optional faults corrupt S[0] or the subtract carry.
  always_comb begin
    if (M) res = {1'b0, A} + {1'b0, ~B} + 5'd1;
    else   res = {1'b0, A} + {1'b0, B};
    if (M && A == 4'b1100 && B == 4'b0111) res = 5'b1_0101;
    if (M && A == 4'b0010 && B == 4'b0111) res = fault_dir ? 5'b1_1011 : 5'b0_1011;
    if (fault_s0) res[0] = 1'b0;
    if (fault_csub && M) res[W] = ~res[W];
  end
  assign S = res[W-1:0];
  assign C = res[W];

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a sweep and count edges from the one that accepts start up to the
  // one that raises done. With hammer set, start is pulsed while busy and
  // held through the FINISH cycle.
  task automatic run_sweep(input logic [1:0] md, input bit hammer, output int n);
    @(posedge clk); #1;
    mode = md;
    start = 1'b1;
    @(posedge clk); #1;
    n = 1;
    start = 1'b0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (!done) start = hammer && (n % 7 == 0);
    end
    start = hammer;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_M", M, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_fail", fail_vec, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Clean add sweep
    d0 = done_cnt;
    run_sweep(2'b00, 1'b0, cyc);
    chk("t1_cycles", cyc, 769);
    chk("t1_err", err_count, 0);
    chk("t1_pass", pass, 1);
    chk("t1_fail", fail_vec, 0);
    chk("t1_A", A, 4'hF);
    chk("t1_B", B, 4'hF);
    chk("t1_M", M, 0);
    chk("t1_busy", busy, 0);
    chk("t1_done_low", done, 0);
    chk("t1_done_cnt", done_cnt - d0, 1);

    // S[0] stuck at 0, add only
    fault_s0 = 1'b1;
    run_sweep(2'b00, 1'b0, cyc);
    fault_s0 = 1'b0;
    chk("t2_err", err_count, 128);
    chk("t2_fail", fail_vec, 9'b0000_0001_0);
    chk("t2_pass", pass, 0);

    // Subtract carry inverted, both operations
    fault_csub = 1'b1;
    run_sweep(2'b10, 1'b0, cyc);
    chk("t3_cycles", cyc, 1537);
    chk("t3_err", err_count, 256);
    chk("t3_fail", fail_vec, 9'b0000_0000_1);
    chk("t3_pass", pass, 0);
    chk("t3_M", M, 1);

    // Mode 11 behaves as mode 10
    run_sweep(2'b11, 1'b0, cyc);
    fault_csub = 1'b0;
    chk("t4_err", err_count, 256);
    chk("t4_fail", fail_vec, 9'b0000_0000_1);

    // Clean subtract sweep with start hammered while busy and in FINISH
    d0 = done_cnt;
    run_sweep(2'b01, 1'b1, cyc);
    chk("t5_cycles", cyc, 769);
    chk("t5_err", err_count, 0);
    chk("t5_pass", pass, 1);
    chk("t5_M", M, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_restart", busy, 0);
    chk("t5_done_cnt", done_cnt - d0, 1);

    // Wrong carry only at A=0010 B=0111 subtract
    fault_dir = 1'b1;
    run_sweep(2'b01, 1'b0, cyc);
    fault_dir = 1'b0;
    chk("t6_err", err_count, 1);
    chk("t6_fail", fail_vec, 9'b0010_0111_1);
    chk("t6_pass", pass, 0);

    // Asynchronous reset mid-sweep
    @(posedge clk); #1;
    mode = 2'b00;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("t7_busy_mid", busy, 1);
    chk("t7_A_mid", A, 4'h6);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("t7_A", A, 0);
    chk("t7_B", B, 0);
    chk("t7_M", M, 0);
    chk("t7_busy", busy, 0);
    chk("t7_err", err_count, 0);
    chk("t7_fail", fail_vec, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t7_no_done", done_cnt - d0, 0);
    rst_n = 1'b1;
    run_sweep(2'b00, 1'b0, cyc);
    chk("t7_cycles", cyc, 769);
    chk("t7_post_err", err_count, 0);
    chk("t7_post_pass", pass, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
